flash_port_arbiter: RTL and testbench

- Sequences and shares the single byte-wide flash port between the instruction-fetch requester and the load/store (memory-stage) requester.
- Converts each 1/2/4-byte little-endian request into a sequence of single-byte flash cycles.
- Returns assembled read data, or scatters write data, and signals completion with a one-cycle done pulse.
- Sits between the pc/cu fetch path and the flash, replacing per-byte flash handling in the pipeline stages.

---
 rtl/flash_port_arbiter.sv | 242 ++++++++++++++++++++++++
 tb/tb_flash_port_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/flash_port_arbiter.sv
// Shares the byte-wide flash port between instruction fetch and load/store.
// Define FLASH_ARB_RR_EN for round-robin conflict arbitration (default: data first).
module flash_port_arbiter #(
    parameter int ADDR_W = 24,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_done,
    output logic              busy,
    output logic              cs,
    output logic              we,
    output logic              re,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        wdata,
    input  logic [7:0]        rdata
);

    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_op_q, wr_op_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        nbytes_q, nbytes_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [31:0]       wbuf_q, wbuf_d;
    logic [31:0]       asm_q, asm_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic              re_q, re_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
`ifdef FLASH_ARB_RR_EN
    logic              last_conf_q, last_conf_d;
`endif

    logic              grant_data;
    logic [2:0]        req_nbytes;
    logic [2:0]        cnt_nxt;
    logic              last_byte;
    logic [ADDR_W-1:0] addr_nxt;

    // Round-robin pointer moves only on contested grants (1 = data won last).
    always_comb begin
        grant_data = d_req;
`ifdef FLASH_ARB_RR_EN
        if (d_req && if_req) begin
            grant_data = ~last_conf_q;
        end
`endif
    end

    always_comb begin
        unique case (d_size)
            2'd0:    req_nbytes = 3'd1;
            2'd1:    req_nbytes = 3'd2;
            default: req_nbytes = 3'd4;
        endcase
    end

    assign cnt_nxt   = cnt_q + 3'd1;
    assign last_byte = (cnt_nxt == nbytes_q);
    assign addr_nxt  = base_q + ADDR_W'(cnt_nxt);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_op_d    = wr_op_q;
        base_d     = base_q;
        nbytes_d   = nbytes_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        wbuf_d     = wbuf_q;
        asm_d      = asm_q;
        cs_d       = cs_q;
        we_d       = we_q;
        re_d       = re_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_done_d  = 1'b0;
        d_done_d   = 1'b0;
`ifdef FLASH_ARB_RR_EN
        last_conf_d = last_conf_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (d_req || if_req) begin
                    owner_d  = grant_data;
                    wr_op_d  = grant_data & d_we;
                    base_d   = grant_data ? d_addr : if_addr;
                    nbytes_d = grant_data ? req_nbytes : 3'd4;
                    wbuf_d   = grant_data ? d_wdata : 32'd0;
                    asm_d    = 32'd0;
                    cnt_d    = 3'd0;
                    lat_d    = '0;
                    cs_d     = 1'b1;
                    we_d     = grant_data & d_we;
                    re_d     = ~(grant_data & d_we);
                    addr_d   = grant_data ? d_addr : if_addr;
                    if (grant_data && d_we) begin
                        wdata_d = d_wdata[7:0];
                    end
`ifdef FLASH_ARB_RR_EN
                    if (d_req && if_req) begin
                        last_conf_d = grant_data;
                    end
`endif
                    state_d = XFER;
                end
            end
            XFER: begin
                if (wr_op_q) begin
                    if (last_byte) begin
                        cs_d    = 1'b0;
                        we_d    = 1'b0;
                        re_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_nxt;
                        addr_d  = addr_nxt;
                        wdata_d = wbuf_q[{cnt_nxt[1:0], 3'b000} +: 8];
                    end
                end else if (lat_q == LAT_LAST) begin
                    asm_d[{cnt_q[1:0], 3'b000} +: 8] = rdata;
                    lat_d = '0;
                    if (last_byte) begin
                        cs_d    = 1'b0;
                        we_d    = 1'b0;
                        re_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        cnt_d  = cnt_nxt;
                        addr_d = addr_nxt;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            DONE: begin
                if (owner_q) begin
                    d_done_d = 1'b1;
                    if (!wr_op_q) begin
                        d_rdata_d = asm_q;
                    end
                end else begin
                    if_done_d  = 1'b1;
                    if_rdata_d = asm_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wr_op_q    <= 1'b0;
            base_q     <= '0;
            nbytes_q   <= 3'd0;
            cnt_q      <= 3'd0;
            lat_q      <= '0;
            wbuf_q     <= 32'd0;
            asm_q      <= 32'd0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 8'd0;
            if_rdata_q <= 32'd0;
            d_rdata_q  <= 32'd0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
`ifdef FLASH_ARB_RR_EN
            last_conf_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_op_q    <= wr_op_d;
            base_q     <= base_d;
            nbytes_q   <= nbytes_d;
            cnt_q      <= cnt_d;
            lat_q      <= lat_d;
            wbuf_q     <= wbuf_d;
            asm_q      <= asm_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            re_q       <= re_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_done_q  <= if_done_d;
            d_done_q   <= d_done_d;
`ifdef FLASH_ARB_RR_EN
            last_conf_q <= last_conf_d;
`endif
        end
    end

    assign busy     = (state_q != IDLE);
    assign cs       = cs_q;
    assign we       = we_q;
    assign re       = re_q;
    assign addr     = addr_q;
    assign wdata    = wdata_q;
    assign if_rdata = if_rdata_q;
    assign if_done  = if_done_q;
    assign d_rdata  = d_rdata_q;
    assign d_done   = d_done_q;

endmodule

// File: tb/tb_flash_port_arbiter.sv
// Directed bench for flash_port_arbiter with a small byte-wide flash model.
module tb_flash_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [23:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        busy;
    logic        cs;
    logic        we;
    logic        re;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [256];
    logic [23:0] rd_log [$];
    logic [31:0] wr_log [$];

    flash_port_arbiter #(.ADDR_W(24), .RD_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_size(d_size),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .busy(busy), .cs(cs), .we(we), .re(re),
        .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Flash: contents reload while rst is high; output is registered.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 1);
            mem[8'h00] <= 8'h83;
            mem[8'h01] <= 8'h02;
            mem[8'h02] <= 8'h00;
            mem[8'h03] <= 8'h02;
            mem[8'h20] <= 8'h81;
            mem[8'hFF] <= 8'h5A;
        end else if (cs && we) begin
            mem[addr[7:0]] <= wdata;
        end
        rdata <= mem[addr[7:0]];
    end

    always @(negedge clk) begin
        if (cs && re) rd_log.push_back(addr);
        if (cs && we) wr_log.push_back({addr, wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit dp, input bit w, input logic [1:0] sz,
                       input logic [23:0] a, input logic [31:0] wd,
                       output int cyc);
        bit ok;
        @(negedge clk);
        if (dp) begin
            d_we = w; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
        end else begin
            if_addr = a; if_req = 1'b1;
        end
        cyc = 0;
        ok = 1'b0;
        while (cyc < 200 && !ok) begin
            @(negedge clk);
            cyc++;
            ok = dp ? d_done : if_done;
        end
        d_req = 1'b0;
        if_req = 1'b0;
        chk("done_seen", 64'(ok), 64'd1);
        chk("other_done_low", 64'(dp ? if_done : d_done), 64'd0);
    endtask

    task automatic conflict(output int dc, output int ic);
        int c;
        dc = 0; ic = 0; c = 0;
        @(negedge clk);
        d_we = 1'b0; d_size = 2'd0; d_addr = 24'h000020;
        if_addr = 24'h000000;
        d_req = 1'b1; if_req = 1'b1;
        while (c < 200 && (dc == 0 || ic == 0)) begin
            @(negedge clk);
            c++;
            if (d_done) begin dc = c; d_req = 1'b0; end
            if (if_done) begin ic = c; if_req = 1'b0; end
        end
        d_req = 1'b0;
        if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, rb, wb, dc, ic, seen;
        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_size = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {cs, we, re, busy, if_done, d_done}, 0);
        chk("rst_addr", {addr, wdata}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        rst = 1'b0;

        // Word fetch: 4 bursts of 3 read cycles.
        rb = rd_log.size();
        run(0, 0, 2'd0, 24'h000000, 0, cyc);
        chk("fetch_lat", cyc, 14);
        chk("fetch_data", if_rdata, 32'h02000283);
        chk("fetch_nrd", rd_log.size() - rb, 12);
        chk("fetch_a0", rd_log[rb + 2], 24'h0);
        chk("fetch_a1", rd_log[rb + 3], 24'h1);
        chk("fetch_a2", rd_log[rb + 8], 24'h2);
        chk("fetch_a3", rd_log[rb + 11], 24'h3);
        chk("fetch_cs_off", {cs, re, busy}, 0);

        // Byte load.
        run(1, 0, 2'd0, 24'h000020, 0, cyc);
        chk("lb_lat", cyc, 5);
        chk("lb_data", d_rdata, 32'h00000081);
        chk("lb_if_hold", if_rdata, 32'h02000283);

        // Word store: one write cycle per byte.
        rb = rd_log.size();
        wb = wr_log.size();
        run(1, 1, 2'd2, 24'h000010, 32'hDEADBEEF, cyc);
        chk("sw_lat", cyc, 6);
        chk("sw_nwr", wr_log.size() - wb, 4);
        chk("sw_nrd", rd_log.size() - rb, 0);
        chk("sw_b0", wr_log[wb + 0], 32'h000010EF);
        chk("sw_b1", wr_log[wb + 1], 32'h000011BE);
        chk("sw_b2", wr_log[wb + 2], 32'h000012AD);
        chk("sw_b3", wr_log[wb + 3], 32'h000013DE);
        chk("sw_rdata_hold", d_rdata, 32'h00000081);

        // Read back with size 3 (acts as word).
        run(1, 0, 2'd3, 24'h000010, 0, cyc);
        chk("lw_lat", cyc, 14);
        chk("lw_data", d_rdata, 32'hDEADBEEF);

        // Half load wrapping past the top of the address space.
        rb = rd_log.size();
        run(1, 0, 2'd1, 24'hFFFFFF, 0, cyc);
        chk("wrap_lat", cyc, 8);
        chk("wrap_data", d_rdata, 32'h0000835A);
        chk("wrap_nrd", rd_log.size() - rb, 6);
        chk("wrap_a0", rd_log[rb + 0], 24'hFFFFFF);
        chk("wrap_a1", rd_log[rb + 3], 24'h000000);

        // Reset during byte 2 of a fetch.
        @(negedge clk);
        if_addr = 24'h000000;
        if_req = 1'b1;
        repeat (7) @(negedge clk);
        chk("mid_addr", addr, 24'h2);
        chk("mid_busy", {cs, re, busy}, 3'b111);
        #1 rst = 1'b1;
        #1 chk("rst_async", {cs, re, busy}, 0);
        if_req = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_done || d_done) seen = 1;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (if_done || d_done) seen = 1;
        end
        chk("rst_no_done", seen, 0);
        chk("rst_if_rdata", if_rdata, 0);
        run(0, 0, 2'd0, 24'h000000, 0, cyc);
        chk("refetch_lat", cyc, 14);
        chk("refetch_data", if_rdata, 32'h02000283);

        // Simultaneous requests, twice.
        conflict(dc, ic);
        chk("conf1_d", dc, 5);
        chk("conf1_i", ic, 19);
        conflict(dc, ic);
`ifdef FLASH_ARB_RR_EN
        chk("conf2_i", ic, 14);
        chk("conf2_d", dc, 19);
`else
        chk("conf2_d", dc, 5);
        chk("conf2_i", ic, 19);
`endif
        chk("conf_d_data", d_rdata, 32'h00000081);
        chk("conf_i_data", if_rdata, 32'h02000283);

        @(negedge clk);
        chk("end_idle", {busy, cs}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
